// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// FSM encoding, NOP filler word and response bundle used by the top and the bench.
package imem_responder_pkg;

   typedef enum logic [1:0] {
      IMEM_IDLE,
      IMEM_WAIT,
      IMEM_RESP
   } imem_state_enum;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic        rvalid;
      logic        err;
      logic [31:0] rdata;
   } imem_resp;

endpackage

// File: rtl/imem_responder_array.sv
// DEPTH x 32 instruction storage: synchronous load write port, synchronous fetch read port.
// One-cycle read; read data holds until the next read; same-address collision returns the old word.
module imem_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];

   // Both ports on one edge with non-blocking updates gives read-before-write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem_q[raddr];
      end
   end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side responder: one request at a time, response strobe LATENCY cycles after accept.
// mem_rdy low while waiting or in reset; IMEM_ERR_EN enables alignment/range error responses.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        proc_req,
   input  logic [31:0] proc_addr,
   output logic        mem_rdy,
   output logic        mem_rvalid,
   output logic [31:0] mem_rdata,
   output logic        mem_err,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 2) ? (LATENCY - 2) : 0);

   imem_state_enum state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;
   logic           accept, req_err, arr_re;
   logic [31:0]    arr_rdata;
   imem_resp       resp;

   assign mem_rdy = !rst && (state_q != IMEM_WAIT);
   assign accept  = proc_req && mem_rdy;

`ifdef IMEM_ERR_EN
   assign req_err = (proc_addr[1:0] != 2'b00) || (proc_addr[31:2] >= 30'(DEPTH));
   logic unused_load_bits;
   assign unused_load_bits = ^{load_addr[31:AW+2], load_addr[1:0]};
`else
   assign req_err = 1'b0;
   logic unused_addr_bits;
   assign unused_addr_bits = ^{proc_addr[31:AW+2], proc_addr[1:0],
                               load_addr[31:AW+2], load_addr[1:0]};
`endif

   // Flagged requests never touch the array; the NOP is substituted on output.
   assign arr_re = accept && !req_err;

   imem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (load_en),
      .waddr (load_addr[AW+1:2]),
      .wdata (load_data),
      .re    (arr_re),
      .raddr (proc_addr[AW+1:2]),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IMEM_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (accept) begin
         err_d = req_err;
         if (LATENCY == 1) begin
            state_d = IMEM_RESP;
         end else begin
            state_d = IMEM_WAIT;
            cnt_d   = CNT_INIT;
         end
      end else begin
         case (state_q)
            IMEM_WAIT: begin
               if (cnt_q == '0) begin
                  state_d = IMEM_RESP;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            IMEM_RESP: state_d = IMEM_IDLE;
            default:   state_d = state_q;
         endcase
      end
   end

   always_comb begin
      resp = '0;
      if (state_q == IMEM_RESP) begin
         resp.rvalid = 1'b1;
         resp.err    = err_q;
         resp.rdata  = err_q ? NOP_INSTR : arr_rdata;
      end
   end

   assign mem_rvalid = resp.rvalid;
   assign mem_err    = resp.err;
   assign mem_rdata  = resp.rdata;

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the memory-side end of the fetch handshake driven by the core's memory FSM (STARTUP…IDLE/MEMREAD/RESTART). Accepts one word-aligned fetch request at a time, returns the 32-bit instruction after a fixed latency with a one-cycle valid strobe, and provides a side-band load port for preloading program images. Sits between the IF-stage fetch FSM and the instruction storage.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, ≥ 2.
- LATENCY, 2: cycles from request acceptance to response; ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- proc_req  in  1  fetch request from the core FSM.
- proc_addr  in  32  byte address of the fetch.
- mem_rdy  out  1  responder can accept a request this cycle.
- mem_rvalid  out  1  response strobe; one cycle per accepted request.
- mem_rdata  out  32  instruction word; meaningful only while mem_rvalid.
- mem_err  out  1  response error flag; qualified by mem_rvalid.
- load_en  in  1  preload write enable.
- load_addr  in  32  preload byte address; word index = load_addr[log2(DEPTH)+1:2].
- load_data  in  32  preload word.

## Operation
- States: IMEM_IDLE, IMEM_WAIT, IMEM_RESP.
- mem_rdy = 1 in IMEM_IDLE and IMEM_RESP, 0 in IMEM_WAIT and while rst is high.
- Acceptance: proc_req & mem_rdy at a rising edge. The array is read at proc_addr's word index on that edge and held in a response register.
- Transitions on acceptance: LATENCY = 1 → IMEM_RESP; LATENCY ≥ 2 → IMEM_WAIT, counter loaded with LATENCY-2.
- IMEM_WAIT: counter decrements each cycle; at 0 → IMEM_RESP. proc_req is ignored.
- IMEM_RESP: mem_rvalid = 1, mem_rdata and mem_err driven from the response register. A new acceptance in this cycle follows the acceptance transitions; otherwise → IMEM_IDLE.
- Error rule (when the error feature is compiled in): the request is flagged if proc_addr[1:0] ≠ 0 or proc_addr[31:2] ≥ DEPTH. A flagged response returns mem_err = 1 and mem_rdata = 32'h00000013 (NOP). The array is not read.
- Load port:
  - Independent of the FSM. Writes on any edge with load_en = 1, including during reset.
  - Read-before-write: an acceptance and a load to the same word on the same edge returns the old word.
  - A load after acceptance does not alter the captured response.
- Array contents are not reset.

## Timing
- Reset values: state IMEM_IDLE, mem_rvalid 0, mem_rdata 0, mem_err 0, counter 0, mem_rdy 0 while rst is high.
- mem_rdy is 1 in the first cycle after rst deasserts.
- Latency: request accepted at edge t → mem_rvalid high during the cycle following edge t+LATENCY-1, i.e. LATENCY cycles later.
- Throughput:
  - LATENCY = 1: back-to-back, one response per cycle.
  - LATENCY = L ≥ 2: one response every L cycles with continuous proc_req.
- Reset mid-operation: the pending response is dropped and mem_rvalid is 0 in the cycle after the reset edge. No late strobe follows.
- mem_rvalid is never high for two cycles for one request. A second strobe occurs only for a second acceptance.

## Configuration
- IMEM_ERR_EN defined: alignment and range checks active as in the error rule.
- IMEM_ERR_EN undefined:
  - mem_err is tied to 0.
  - proc_addr[1:0] is ignored.
  - The word index wraps modulo DEPTH (proc_addr[log2(DEPTH)+1:2]).

## Structure
- Shared package gets the following; the FSM encoding is not defined locally:
  - imem_state_enum {IMEM_IDLE, IMEM_WAIT, IMEM_RESP}.
  - NOP_INSTR = 32'h00000013.
  - A packed struct imem_resp {rvalid, err, rdata[31:0]}.
- One sub-module, imem_array: DEPTH×32 storage, synchronous write port (load), synchronous read port (accept). Read-before-write on same-address collision.

## Test plan
- Preload word 5 = 32'hDEADBEEF. After reset, request proc_addr 0x14 with LATENCY = 2 → mem_rdy drops for 1 cycle, then mem_rvalid high for exactly one cycle 2 cycles after acceptance, with mem_rdata 0xDEADBEEF and mem_err 0.
- LATENCY = 1, proc_req held high over addresses 0x0, 0x4, 0x8 preloaded 1, 2, 3 → mem_rvalid high for 3 consecutive cycles, data 1, 2, 3, mem_rdy constantly 1.
- IMEM_ERR_EN defined, DEPTH = 1024:
  - Request 0x1002 → mem_err 1, mem_rdata 0x00000013.
  - Request 0x1000 (index 1024) → same error response.
- IMEM_ERR_EN undefined, DEPTH = 1024: request 0x1000 → mem_rdata equals word 0, mem_err 0.
- Accept a request to word 7 and assert rst at the next edge → no mem_rvalid ever follows; mem_rdy 0 during reset, 1 in the first cycle after.
- Accept word 3 while load_en writes 0x12345678 to word 3 on the same edge → response returns the old value. A subsequent request returns 0x12345678.
